// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes, flag bit indices, scheduler sizing constants and FSM state encoding.
package alu_pkg;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 6;
  localparam int NUM_OPS = 24;
  localparam logic [CTRL_W-1:0] IDLE_OP = 6'd63;
  localparam logic [CTRL_W-1:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_AND = 6'd2, OP_OR = 6'd3,
    OP_XOR = 6'd4, OP_NOT = 6'd5, OP_SHL = 6'd6, OP_SHR = 6'd7, OP_SAR = 6'd8, OP_ROL = 6'd9,
    OP_ROR = 6'd10, OP_RCL = 6'd11, OP_RCR = 6'd12, OP_ADC = 6'd13, OP_SBB = 6'd14,
    OP_INC = 6'd15, OP_DEC = 6'd16, OP_NEG = 6'd17, OP_CMP = 6'd18, OP_TST = 6'd19,
    OP_ADD_B = 6'd20, OP_SUB_B = 6'd21, OP_RCL_B = 6'd22, OP_RCR_B = 6'd23;
  localparam int FLG_N = 0, FLG_C = 1, FLG_Z = 2, FLG_V = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CAPT, ST_RESP} sched_state_t;
endpackage

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: 2-way round-robin grant for the ALU scheduler.
// With ALU_SCHED_PRIO_EN defined it becomes fixed priority (req0 wins) and no pointer is built.
module alu_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
`ifdef ALU_SCHED_PRIO_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign grant = !en ? 2'b00 : valid[0] ? 2'b01 : valid;
`else
  logic last;
  assign grant = !en ? 2'b00 : &valid ? (last ? 2'b01 : 2'b10) : valid;
  // a grant is always taken in the same cycle, so any grant is an accept
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= 1'b1;
    else if (|grant) last <= grant[1];
`endif
endmodule

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: shares one registered-latency ALU between two requesters with a
// valid/ready response register; ALU_SCHED_PRIO_EN selects fixed priority arbitration.
module alu_op_scheduler
  import alu_pkg::*;
(
  input  logic                alu_clk,
  input  logic                alu_rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*CTRL_W-1:0] req_op,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [3:0]          rsp_flags,
  output logic                rsp_err,
  output logic [CTRL_W-1:0]   alu_ctrl,
  output logic [DATA_W-1:0]   alu_in_1,
  output logic [DATA_W-1:0]   alu_in_2,
  input  logic [DATA_W-1:0]   alu_rslt,
  input  logic [3:0]          alu_checks
);
  sched_state_t state, state_nxt;
  logic idle, acc, win, legal;
  logic [CTRL_W-1:0] op_w;
  logic [DATA_W-1:0] a_w, b_w;
  assign idle = state == ST_IDLE && !alu_rst;
  alu_rr_arbiter u_arb (.clk(alu_clk), .rst(alu_rst), .en(idle), .valid(req_valid), .grant(req_ready));
  assign acc = |req_ready;
  assign win = req_ready[1];
  assign op_w = win ? req_op[2*CTRL_W-1:CTRL_W] : req_op[CTRL_W-1:0];
  assign a_w = win ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
  assign b_w = win ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
  assign legal = op_w < CTRL_W'(NUM_OPS);
  always_ff @(posedge alu_clk or posedge alu_rst)
    if (alu_rst) state <= ST_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == ST_IDLE ? (acc ? (legal ? ST_EXEC : ST_RESP) : ST_IDLE) :
                state == ST_EXEC ? ST_CAPT :
                state == ST_CAPT ? ST_RESP :
                rsp_ready ? ST_IDLE : ST_RESP;
  end
  // illegal opcodes answer straight from IDLE and never touch the ALU inputs
  always_ff @(posedge alu_clk or posedge alu_rst)
    if (alu_rst) begin
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_data <= '0;
      rsp_flags <= '0;
      rsp_err <= 1'b0;
      alu_ctrl <= IDLE_OP;
      alu_in_1 <= '0;
      alu_in_2 <= '0;
    end else if (acc) begin
      rsp_id <= win;
      if (legal) begin
        alu_ctrl <= op_w;
        alu_in_1 <= a_w;
        alu_in_2 <= b_w;
      end else begin
        rsp_data <= '0;
        rsp_flags <= '0;
        rsp_err <= 1'b1;
        rsp_valid <= 1'b1;
      end
    end else if (state == ST_CAPT) begin
      rsp_data <= alu_rslt;
      rsp_flags <= alu_checks;
      rsp_err <= 1'b0;
      rsp_valid <= 1'b1;
    end else if (state == ST_RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
      alu_ctrl <= IDLE_OP;
    end
endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb_alu_op_scheduler: scoreboard bench with a behavioural ALU and arbitration reference model.
module tb_alu_op_scheduler;
  import alu_pkg::*;
`ifdef ALU_SCHED_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  typedef struct {
    logic id;
    logic err;
    logic [3:0] flags;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    int lat;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, rsp_ready = 1'b1;
  logic [1:0] vld = '0;
  logic [1:0][CTRL_W-1:0] opv = '0;
  logic [1:0][DATA_W-1:0] av = '0, bv = '0;
  logic [1:0] req_ready;
  logic rsp_valid, rsp_id, rsp_err;
  logic [3:0] rsp_flags, alu_checks;
  logic [DATA_W-1:0] rsp_data, alu_in_1, alu_in_2, alu_rslt;
  logic [CTRL_W-1:0] alu_ctrl;

  int checks = 0, errors = 0, since = 0, n_acc = 0;
  bit busy = 0, shown = 0, prev_hold = 0, last_g = 1;
  logic [1:0] acc_n = '0;
  logic [38:0] prev_b;
  logic last_id, last_err;
  logic [3:0] last_flags;
  logic [DATA_W-1:0] last_data;
  exp_t q[$];
  logic ids[$];

  always #5 clk = ~clk;

  alu_op_scheduler dut (
    .alu_clk(clk), .alu_rst(rst), .req_valid(vld), .req_ready(req_ready),
    .req_op(opv), .req_a(av), .req_b(bv), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_ctrl(alu_ctrl), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .alu_rslt(alu_rslt), .alu_checks(alu_checks)
  );

  // behavioural ALU: {flags {V,Z,C,N}, result}; unknown opcodes give 0 with Z set
  function automatic logic [35:0] alu_f(logic [CTRL_W-1:0] op, logic [DATA_W-1:0] x, logic [DATA_W-1:0] y);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    if (op == OP_ADD) begin
      s = {1'b0, x} + {1'b0, y};
      r = s[31:0];
      c = s[32];
      v = (x[31] == y[31]) && (r[31] != x[31]);
    end else if (op == OP_SUB) begin
      s = {1'b0, x} - {1'b0, y};
      r = s[31:0];
      c = ~s[32];
      v = (x[31] != y[31]) && (r[31] != x[31]);
    end else if (op < NUM_OPS) r = (x ^ {y[15:0], y[31:16]}) + {26'd0, op};
    else r = 32'd0;
    return {v, r == 32'd0, c, r[31], r};
  endfunction

  always @(posedge clk) {alu_checks, alu_rslt} <= alu_f(alu_ctrl, alu_in_1, alu_in_2);

  function automatic logic [1:0] model_grant(logic [1:0] v);
    if (PRIO) return v[0] ? 2'b01 : v;
    return (&v) ? (last_g ? 2'b01 : 2'b10) : v;
  endfunction

  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_alu_ctrl", alu_ctrl, IDLE_OP);
      q.delete();
      busy = 0;
      shown = 0;
      prev_hold = 0;
      last_g = 1;
      acc_n = '0;
    end else begin
      chk("req_ready", req_ready, busy ? 2'b00 : model_grant(vld));
      if (!busy) chk("alu_ctrl_idle", alu_ctrl, IDLE_OP);
      acc_n = vld & req_ready;
      if (prev_hold) chk("rsp_hold", {rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_data}, prev_b);
      if (busy) begin
        since++;
        if (q.size() > 0 && since == 1 && !q[0].err)
          chk("alu_issue", {alu_ctrl, alu_in_1, alu_in_2}, {q[0].op, q[0].a, q[0].b});
        if (q.size() > 0 && q[0].err) chk("alu_ctrl_illegal", alu_ctrl, IDLE_OP);
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected actual=valid required=none id=%0d data=%0h", rsp_id, rsp_data);
        end else begin
          if (!shown) begin
            chk("rsp_latency", since, q[0].lat);
            chk("rsp", {rsp_id, rsp_err, rsp_flags, rsp_data}, {q[0].id, q[0].err, q[0].flags, q[0].data});
            shown = 1;
          end
          if (rsp_ready) begin
            {last_id, last_err, last_flags, last_data} = {rsp_id, rsp_err, rsp_flags, rsp_data};
            void'(q.pop_front());
            busy = 0;
            shown = 0;
          end
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_b = {rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_data};
      if (|acc_n) begin
        exp_t e;
        e.id = acc_n[1];
        e.op = opv[e.id];
        e.a = av[e.id];
        e.b = bv[e.id];
        e.err = e.op >= NUM_OPS;
        e.lat = e.err ? 1 : 3;
        {e.flags, e.data} = e.err ? 36'd0 : alu_f(e.op, e.a, e.b);
        q.push_back(e);
        ids.push_back(e.id);
        busy = 1;
        since = 0;
        n_acc++;
        last_g = e.id;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    vld = vld & ~acc_n;
  endtask

  task automatic post(int r, logic [CTRL_W-1:0] o, logic [DATA_W-1:0] x, logic [DATA_W-1:0] y);
    opv[r] = o;
    av[r] = x;
    bv[r] = y;
    vld[r] = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((vld != 0 || busy || q.size() != 0) && n < 60) begin
      cyc();
      n++;
    end
    if (vld != 0 || busy || q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_done timeout actual=busy required=idle");
    end
  endtask

  task automatic do_reset();
    vld = '0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] rnd_d();
    int k = $urandom_range(0, 3);
    return k == 0 ? 32'd0 : k == 1 ? 32'hFFFF_FFFF : k == 2 ? 32'h8000_0000 : $urandom;
  endfunction

  initial begin
    int n;
    do_reset();
    post(0, OP_ADD, 5, 7);
    wait_done();
    chk("add_5_7", {last_id, last_err, last_flags, last_data}, {1'b0, 1'b0, 4'b0000, 32'd12});
    post(1, OP_SUB, 3, 3);
    wait_done();
    chk("sub_3_3", {last_id, last_err, last_flags, last_data}, {1'b1, 1'b0, 4'b0110, 32'd0});

    do_reset();
    ids.delete();
    n_acc = 0;
    while (n_acc < 4) begin
      cyc();
      if (!vld[0]) post(0, OP_ADD, $urandom, $urandom);
      if (!vld[1]) post(1, OP_ADD, $urandom, $urandom);
    end
    vld = '0;
    wait_done();
    for (int i = 0; i < 4; i++) chk("arb_order", ids[i], PRIO ? 1'b0 : 1'(i % 2));

    post(0, 6'd30, 9, 9);
    wait_done();
    chk("illegal_op", {last_id, last_err, last_flags, last_data}, {1'b0, 1'b1, 4'b0000, 32'd0});

    rsp_ready = 1'b0;
    post(0, OP_ADD, 32'hFFFF_FFFF, 1);
    repeat (3) cyc();
    post(1, OP_ADD, 2, 2);
    repeat (5) cyc();
    chk("stall", {rsp_valid, rsp_flags, rsp_data, req_ready}, {1'b1, 4'b0110, 32'd0, 2'b00});
    rsp_ready = 1'b1;
    wait_done();
    chk("after_stall", {last_id, last_data}, {1'b1, 32'd4});

    post(0, OP_ADD, 1, 2);
    n = 0;
    while (!busy && n < 20) begin
      cyc();
      n++;
    end
    chk("exec_ctrl", alu_ctrl, OP_ADD);
    rst = 1'b1;
    #1;
    chk("rst_async", {alu_ctrl, alu_in_1, alu_in_2, rsp_valid}, {IDLE_OP, 65'd0});
    cyc();
    rst = 1'b0;
    repeat (6) cyc();
    post(1, OP_SUB, 10, 4);
    wait_done();
    chk("post_rst", {last_id, last_err, last_data}, {1'b1, 1'b0, 32'd6});

    for (int i = 0; i < 600; i++) begin
      cyc();
      rsp_ready = $urandom_range(0, 3) != 0;
      for (int r = 0; r < 2; r++)
        if (!vld[r] && $urandom_range(0, 2) == 0)
          post(r, $urandom_range(0, 3) == 0 ? 6'($urandom_range(24, 63)) : 6'($urandom_range(0, 23)), rnd_d(), rnd_d());
        else if (vld[r] && $urandom_range(0, 19) == 0) vld[r] = 1'b0;
    end
    rsp_ready = 1'b1;
    vld = '0;
    wait_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule
